// File: rtl/rotshift_pipe.sv
// rotshift_pipe: pipelined barrel shifter/rotator for the ALU shift path.
// One binary stage per count bit; stage k moves the operand by 2^k when its
// count bit is set. Each stage is registered and the whole pipe advances in
// lock-step, stalling only when the output holds an unaccepted result.
module rotshift_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_cnt,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_SRA = 2'b11;

  // One stage of the shifter: move d by s positions when en is set.
  // SRA takes its sign from d itself, so chained stages compose into a
  // single arithmetic shift by the full count.
  function automatic logic [WIDTH-1:0] stage_op(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             en,
    input int unsigned      s
  );
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (mode)
        MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
        MODE_SLL: r = d << s;
        MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
        MODE_SRA: r = $unsigned($signed(d) >>> s);
        default:  r = d;
      endcase
    end else begin
      r = d;
    end
    return r;
  endfunction

  // The pipe moves forward whenever the output slot is empty or being drained.
  logic advance_s;
  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < CNT_W; k++) begin : stg
    logic             v_in_s;
    logic [WIDTH-1:0] d_in_s;
    logic [CNT_W-1:0] c_in_s;
    logic [1:0]       m_in_s;
    logic [WIDTH-1:0] d_nxt_s;
    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // Stage 0 is fed from the input port; later stages from the previous register.
    // The count arrives pre-shifted so that bit 0 is always this stage's bit.
    if (k == 0) begin : g_src
      assign v_in_s = in_valid;
      assign d_in_s = in_data;
      assign c_in_s = in_cnt;
      assign m_in_s = in_mode;
    end else begin : g_src
      assign v_in_s = stg[k-1].valid_r;
      assign d_in_s = stg[k-1].data_r;
      assign c_in_s = stg[k-1].g_fwd.cnt_r;
      assign m_in_s = stg[k-1].g_fwd.mode_r;
    end

    assign d_nxt_s = stage_op(d_in_s, m_in_s, c_in_s[0], 32'(1) << k);

    // Stage valid/data register: loads on advance, holds during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        data_r  <= {WIDTH{1'b0}};
      end else if (advance_s) begin
        valid_r <= v_in_s;
        data_r  <= d_nxt_s;
      end
    end

    // Count and mode only need to travel to the stages that still use them.
    if (k < CNT_W - 1) begin : g_fwd
      logic [CNT_W-1:0] cnt_r;
      logic [1:0]       mode_r;

      // Sideband register: carries the remaining count bits and the mode.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r  <= {CNT_W{1'b0}};
          mode_r <= 2'b00;
        end else if (advance_s) begin
          cnt_r  <= c_in_s >> 1;
          mode_r <= m_in_s;
        end
      end
    end
  end

  assign out_valid = stg[CNT_W-1].valid_r;
  assign out_data  = stg[CNT_W-1].data_r;

endmodule
